gyro_integrator: RTL

Consumes the three signed 16-bit angular-rate words published by the Pmod GYRO SPI reader (`data_x/y/z`) and turns them into bias-corrected, saturating integrated angles per axis. The reader exposes static registers with no valid strobe, so this block owns the sampling cadence: a divider fires a sample tick every `SAMPLE_DIV` cycles. After reset or a recalibration request, the block averages a fixed number of samples to estimate the bias. It then integrates the bias-corrected rate until the angles are cleared or recalibration is requested. Sits between the SPI reader and the game/display logic.

---
 rtl/gyro_integrator_pkg.sv | 16 +
 rtl/gyro_integrator_if.sv | 29 ++
 rtl/gyro_integrator_axis.sv | 83 ++++++++
 rtl/gyro_integrator.sv | 114 +++++++++++
 4 files changed

// File: rtl/gyro_integrator_pkg.sv
// gyro_pkg: shared state type, widths and saturation limits for the
// gyro integrator. Optional deadband: GYRO_DEADBAND_EN.
package gyro_pkg;

  typedef enum logic {CAL, RUN} state_t;

  localparam int ACC_W   = 32;
  localparam int RATE_W  = 16;
  localparam int ANGLE_W = 16;

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/gyro_integrator_if.sv
// gyro_integrator_if: rate inputs, control pulses and angle outputs.
// Optional deadband: GYRO_DEADBAND_EN.
interface gyro_integrator_if;
  import gyro_pkg::*;

  logic signed [RATE_W-1:0]  rate_x;
  logic signed [RATE_W-1:0]  rate_y;
  logic signed [RATE_W-1:0]  rate_z;
  logic                      zero;
  logic                      recal;
  logic signed [ANGLE_W-1:0] angle_x;
  logic signed [ANGLE_W-1:0] angle_y;
  logic signed [ANGLE_W-1:0] angle_z;
  logic                      out_valid;
  logic                      cal_done;

  modport master (
    output rate_x, rate_y, rate_z, zero, recal,
    input  angle_x, angle_y, angle_z,
    input  out_valid, cal_done
  );

  modport slave (
    input  rate_x, rate_y, rate_z, zero, recal,
    output angle_x, angle_y, angle_z,
    output out_valid, cal_done
  );

endinterface

// File: rtl/gyro_integrator_axis.sv
// gyro_axis_integ: one axis of bias averaging and saturating integration.
// Optional deadband on the corrected rate: GYRO_DEADBAND_EN.
module gyro_axis_integ
  import gyro_pkg::*;
#(
  parameter int CAL_LOG2 = 8
`ifdef GYRO_DEADBAND_EN
  , parameter int DEADBAND = 8
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [RATE_W-1:0]  rate,
  input  logic                      tick,
  input  logic                      cal_phase,
  input  logic                      cal_last,
  input  logic                      clr_acc,
  input  logic                      clr_cal,
  output logic signed [ANGLE_W-1:0] angle
);

  localparam int SUM_W = RATE_W + CAL_LOG2;

  logic signed [SUM_W-1:0]  sum_q;
  logic signed [SUM_W-1:0]  sum_nx;
  logic signed [RATE_W-1:0] bias_q;
  logic signed [RATE_W:0]   diff;
  logic signed [RATE_W:0]   diff_db;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_sat;
  logic signed [ACC_W:0]    acc_sum;

  assign sum_nx = sum_q
    + {{CAL_LOG2{rate[RATE_W-1]}}, rate};

  assign diff = {rate[RATE_W-1], rate}
    - {bias_q[RATE_W-1], bias_q};

`ifdef GYRO_DEADBAND_EN
  logic [RATE_W:0] mag;
  assign mag = diff[RATE_W] ? -diff : diff;
  assign diff_db =
    (mag <= (RATE_W+1)'(DEADBAND)) ? '0 : diff;
`else
  assign diff_db = diff;
`endif

  assign acc_sum = {acc_q[ACC_W-1], acc_q}
    + {{(ACC_W-RATE_W){diff_db[RATE_W]}}, diff_db};

  // One guard bit: sign disagreement means overflow
  always_comb begin
    acc_sat = acc_sum[ACC_W-1:0];
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
      acc_sat = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      bias_q <= '0;
      acc_q  <= '0;
    end else begin
      if (clr_cal) begin
        sum_q <= '0;
      end else if (tick && cal_phase) begin
        if (cal_last) begin
          sum_q  <= '0;
          bias_q <= sum_nx[SUM_W-1:CAL_LOG2];
        end else begin
          sum_q <= sum_nx;
        end
      end
      if (clr_acc)
        acc_q <= '0;
      else if (tick && !cal_phase)
        acc_q <= acc_sat;
    end
  end

  assign angle = acc_q[ACC_W-1 -: ANGLE_W];

endmodule

// File: rtl/gyro_integrator.sv
// gyro_integrator: sample divider, CAL/RUN control and three axes.
// Optional deadband on the corrected rate: GYRO_DEADBAND_EN.
module gyro_integrator
  import gyro_pkg::*;
#(
  parameter int SAMPLE_DIV = 100000,
  parameter int CAL_LOG2   = 8,
  parameter int DEADBAND   = 8
) (
  input logic               clk,
  input logic               rst,
  gyro_integrator_if.slave  bus
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int CNT_W = CAL_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((1 << CAL_LOG2) - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic             cal_phase;
  logic             cal_last;
  logic             clr_acc;
  logic             clr_cal;

  // Free-running: only rst restarts the sample cadence
  assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick)
      div_q <= '0;
    else
      div_q <= div_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CAL;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ov_d     = 1'b0;
    cal_last = 1'b0;
    clr_acc  = 1'b0;
    clr_cal  = 1'b0;
    if (bus.recal) begin
      state_d = CAL;
      cnt_d   = '0;
      clr_acc = 1'b1;
      clr_cal = 1'b1;
    end else if (state_q == CAL) begin
      if (tick) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cal_last = 1'b1;
          cnt_d    = '0;
          clr_acc  = 1'b1;
          state_d  = RUN;
        end
      end
    end else begin
      ov_d    = tick;
      clr_acc = bus.zero;
    end
  end

  assign cal_phase = (state_q == CAL);

  logic signed [RATE_W-1:0]  rate  [3];
  logic signed [ANGLE_W-1:0] angle [3];

  assign rate[0] = bus.rate_x;
  assign rate[1] = bus.rate_y;
  assign rate[2] = bus.rate_z;

  for (genvar a = 0; a < 3; a++) begin : g_axis
    gyro_axis_integ #(
      .CAL_LOG2 (CAL_LOG2)
`ifdef GYRO_DEADBAND_EN
      , .DEADBAND (DEADBAND)
`endif
    ) u_axis (
      .clk       (clk),
      .rst       (rst),
      .rate      (rate[a]),
      .tick      (tick),
      .cal_phase (cal_phase),
      .cal_last  (cal_last),
      .clr_acc   (clr_acc),
      .clr_cal   (clr_cal),
      .angle     (angle[a])
    );
  end

  assign bus.angle_x   = angle[0];
  assign bus.angle_y   = angle[1];
  assign bus.angle_z   = angle[2];
  assign bus.out_valid = ov_q;
  assign bus.cal_done  = (state_q == RUN);

endmodule
